spi_flash_responder: RTL and testbench

Responder-side model of the serial flash that the MCU's SPI/QSPI flash controller talks to. It sits on the controller's six flash wires (sclk, cs_n, io0..io3) in place of a physical flash chip, decodes the command stream, and serves or accepts data through a synchronous byte-wide memory port. It is used in simulation and in on-FPGA loopback builds to test boot and flash access without a real device.

---
 rtl/spi_flash_responder.sv | 250 +++++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// Serial-flash responder: decodes the SPI/QSPI command stream from a flash controller
// and serves reads / accepts page-program writes through a synchronous byte-wide memory port.
module spi_flash_responder #(
    parameter int          AW       = 16,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016,
    parameter int          DUMMY    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sclk,
    input  logic          cs_n,
    input  logic [3:0]    qdi,
    output logic [3:0]    qdo,
    output logic [3:0]    oe,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [7:0]    mem_rdata,
    output logic          mem_wr,
    output logic [7:0]    mem_wdata
);

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_FREAD = 8'h0B;
    localparam logic [7:0] OP_QREAD = 8'h6B;
    localparam logic [7:0] OP_RDID  = 8'h9F;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_PP    = 8'h02;
    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;

    localparam logic [4:0] DUMMY_LAST = 5'(DUMMY - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DOUT, ST_DIN, ST_IGNORE
    } state_t;

    state_t state, state_nxt;

    logic [2:0]    sclk_sync, cs_sync;
    logic [3:0]    qdi_s1, qdi_s2;
    logic          sclk_rise, sclk_fall, cs_high, cs_fall, io0;
    logic [4:0]    cnt;
    logic [6:0]    in_sr;
    logic [7:0]    in_byte;
    logic [AW-2:0] addr_sr;
    logic [AW-1:0] addr_nxt;
    logic [7:0]    opcode;
    logic [7:0]    out_sr;
    logic [7:0]    load_byte;
    logic [1:0]    id_idx;
    logic          rd_pending;
    logic [7:0]    rd_buf;
    logic          driving;
    logic          wel;
    logic          is_read, quad;
    logic [4:0]    dout_last;
    logic          unused_qdi;

    // cs_n flops reset to "selected" so a select that is already active when rst
    // is released is not seen as a fresh falling edge; cs_n must go high first.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            qdi_s1    <= '0;
            qdi_s2    <= '0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], sclk};
            cs_sync   <= {cs_sync[1:0], cs_n};
            qdi_s1    <= qdi;
            qdi_s2    <= qdi_s1;
        end
    end

    assign sclk_rise  = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall  = ~sclk_sync[1] & sclk_sync[2];
    assign cs_high    = cs_sync[1];
    assign cs_fall    = cs_sync[2] & ~cs_sync[1];
    assign io0        = qdi_s2[0];
    assign unused_qdi = ^qdi_s2[3:1];

    assign in_byte   = {in_sr, io0};
    assign addr_nxt  = {addr_sr, io0};
    assign is_read   = opcode inside {OP_READ, OP_FREAD, OP_QREAD};
    assign quad      = (opcode == OP_QREAD);
    assign dout_last = quad ? 5'd1 : 5'd7;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (cs_high) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (cs_fall) state_nxt = ST_CMD;
                ST_CMD: begin
                    if (sclk_rise && cnt == 5'd7) begin
                        case (in_byte)
                            OP_READ, OP_FREAD, OP_QREAD: state_nxt = ST_ADDR;
                            OP_RDID, OP_RDSR:            state_nxt = ST_DOUT;
                            OP_PP:                       state_nxt = wel ? ST_ADDR : ST_IGNORE;
                            default:                     state_nxt = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise && cnt == 5'd23) begin
                        if (opcode == OP_PP)        state_nxt = ST_DIN;
                        else if (opcode == OP_READ) state_nxt = ST_DOUT;
                        else                        state_nxt = ST_DUMMY;
                    end
                end
                ST_DUMMY: if (sclk_rise && cnt == DUMMY_LAST) state_nxt = ST_DOUT;
                default:  ;
            endcase
        end
    end

    // Pads stay released until the first byte is loaded, so the data phase starts clean.
    always_comb begin
        oe  = 4'b0000;
        qdo = 4'b0000;
        if (state == ST_DOUT && driving) begin
            if (quad) begin
                oe  = 4'b1111;
                qdo = out_sr[7:4];
            end else begin
                oe  = 4'b0010;
                qdo = {2'b00, out_sr[7], 1'b0};
            end
        end
    end

    always_comb begin
        case (opcode)
            OP_RDID: begin
                case (id_idx)
                    2'd0:    load_byte = JEDEC_ID[23:16];
                    2'd1:    load_byte = JEDEC_ID[15:8];
                    default: load_byte = JEDEC_ID[7:0];
                endcase
            end
            OP_RDSR: load_byte = {6'b000000, wel, 1'b0};
            default: load_byte = rd_buf;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            in_sr      <= '0;
            addr_sr    <= '0;
            opcode     <= '0;
            out_sr     <= '0;
            id_idx     <= '0;
            rd_pending <= 1'b0;
            rd_buf     <= '0;
            driving    <= 1'b0;
            wel        <= 1'b0;
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            rd_pending <= mem_rd;
            if (rd_pending) rd_buf <= mem_rdata;
            // Page-program address advances after the strobe so mem_wr pairs with the old address.
            if (mem_wr) mem_addr[7:0] <= mem_addr[7:0] + 8'd1;

            if (cs_high) begin
                if ((state == ST_ADDR || state == ST_DIN) && opcode == OP_PP) wel <= 1'b0;
                cnt     <= '0;
                driving <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        cnt     <= '0;
                        driving <= 1'b0;
                    end
                    ST_CMD: begin
                        if (sclk_rise) begin
                            in_sr <= in_byte[6:0];
                            cnt   <= cnt + 5'd1;
                            if (cnt == 5'd7) begin
                                cnt    <= '0;
                                opcode <= in_byte;
                                id_idx <= 2'd0;
                                if (in_byte == OP_WREN) wel <= 1'b1;
                                if (in_byte == OP_WRDI) wel <= 1'b0;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (sclk_rise) begin
                            addr_sr <= addr_nxt[AW-2:0];
                            cnt     <= cnt + 5'd1;
                            if (cnt == 5'd23) begin
                                cnt      <= '0;
                                mem_addr <= addr_nxt;
                                if (is_read) mem_rd <= 1'b1;
                            end
                        end
                    end
                    ST_DUMMY: begin
                        if (sclk_rise) cnt <= (cnt == DUMMY_LAST) ? 5'd0 : cnt + 5'd1;
                    end
                    ST_DOUT: begin
                        if (sclk_fall) begin
                            driving <= 1'b1;
                            if (cnt == 5'd0) begin
                                out_sr <= load_byte;
                                if (opcode == OP_RDID) id_idx <= (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;
                                if (is_read) begin
                                    mem_addr <= mem_addr + AW'(1);
                                    mem_rd   <= 1'b1;
                                end
                            end else if (quad) begin
                                out_sr <= {out_sr[3:0], 4'b0000};
                            end else begin
                                out_sr <= {out_sr[6:0], 1'b0};
                            end
                            cnt <= (cnt == dout_last) ? 5'd0 : cnt + 5'd1;
                        end
                    end
                    ST_DIN: begin
                        if (sclk_rise) begin
                            in_sr <= in_byte[6:0];
                            cnt   <= cnt + 5'd1;
                            if (cnt == 5'd7) begin
                                cnt       <= '0;
                                mem_wr    <= 1'b1;
                                mem_wdata <= in_byte;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: a bit-banged SPI controller drives the pads, a monitor
// rebuilds output bytes and memory writes and scores them against an expected queue.
module tb_spi_flash_responder;

    localparam int AW   = 16;
    localparam int HALF = 6;

    typedef struct packed {
        logic        is_wr;
        logic [3:0]  oe;
        logic [15:0] addr;
        logic [7:0]  data;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sclk = 1'b0;
    logic          cs_n = 1'b1;
    logic [3:0]    qdi = 4'h0;
    logic [3:0]    qdo;
    logic [3:0]    oe;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [7:0]    mem_rdata = 8'h00;
    logic          mem_wr;
    logic [7:0]    mem_wdata;

    logic [7:0] mem [0:(1<<AW)-1];
    ev_t        exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;

    logic       mon_sclk_prev = 1'b0;
    logic [7:0] mon_sr = 8'h00;
    int         mon_bits = 0;

    always #5 clk = ~clk;

    spi_flash_responder #(.AW(AW), .JEDEC_ID(24'hEF4016), .DUMMY(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .qdi       (qdi),
        .qdo       (qdo),
        .oe        (oe),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata)
    );

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
        if (mem_wr) mem[mem_addr] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic score(input ev_t got);
        ev_t want;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got %h with nothing expected", got);
        end else begin
            want = exp_q.pop_front();
            check(got.is_wr ? "mem_write" : "read_byte", 32'(got), 32'(want));
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (mem_wr) score({1'b1, 4'h0, mem_addr, mem_wdata});
        if (cs_n) begin
            mon_bits = 0;
        end else if (sclk && !mon_sclk_prev && oe != 4'h0) begin
            if (oe == 4'hF) begin
                mon_sr   = {mon_sr[3:0], qdo};
                mon_bits += 4;
            end else begin
                mon_sr   = {mon_sr[6:0], qdo[1]};
                mon_bits += 1;
            end
            if (mon_bits >= 8) begin
                score({1'b0, oe, 16'h0000, mon_sr});
                mon_bits = 0;
            end
        end
        mon_sclk_prev = sclk;
    end

    task automatic exp_rd(input logic [7:0] d, input logic [3:0] oe_v);
        exp_q.push_back({1'b0, oe_v, 16'h0000, d});
    endtask

    task automatic exp_wr(input logic [15:0] a, input logic [7:0] d);
        exp_q.push_back({1'b1, 4'h0, a, d});
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_xfer(input logic b);
        qdi[0] = b;
        wait_clks(HALF);
        sclk = 1'b1;
        wait_clks(HALF);
        sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) bit_xfer(b[i]);
    endtask

    task automatic send_cmd_addr(input logic [7:0] op, input logic [23:0] a);
        send_byte(op);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    task automatic idle_clocks(input int n);
        for (int i = 0; i < n; i++) bit_xfer(1'b0);
    endtask

    task automatic select();
        wait_clks(HALF);
        cs_n = 1'b0;
    endtask

    task automatic deselect(input string name);
        wait_clks(HALF);
        cs_n = 1'b1;
        for (int n = 0; n < 4 && oe != 4'h0; n++) wait_clks(1);
        check(name, 32'(oe), 32'h0);
        wait_clks(2 * HALF);
    endtask

    task automatic read_status(input logic [7:0] want, input string name);
        exp_rd(want, 4'b0010);
        select();
        send_byte(8'h05);
        idle_clocks(8);
        deselect(name);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] <= 8'h00;
        mem[16'hFFFE] <= 8'hA5;
        mem[16'hFFFF] <= 8'h5A;
        mem[16'h0000] <= 8'h11;
        mem[16'h0010] <= 8'h3C;
        mem[16'h0011] <= 8'hC3;

        wait_clks(5);
        check("rst_oe", 32'(oe), 32'h0);
        check("rst_qdo", 32'(qdo), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_strobes", 32'({mem_rd, mem_wr}), 32'h0);
        check("rst_wdata", 32'(mem_wdata), 32'h0);
        rst = 1'b0;
        wait_clks(HALF);

        // JEDEC ID, wraps back to the first byte
        exp_rd(8'hEF, 4'b0010); exp_rd(8'h40, 4'b0010); exp_rd(8'h16, 4'b0010); exp_rd(8'hEF, 4'b0010);
        select();
        send_byte(8'h9F);
        idle_clocks(32);
        deselect("rdid_release");

        // Plain read across the top of the 64 KiB array
        exp_rd(8'hA5, 4'b0010); exp_rd(8'h5A, 4'b0010); exp_rd(8'h11, 4'b0010);
        select();
        send_cmd_addr(8'h03, 24'h00FFFE);
        idle_clocks(24);
        deselect("read_release");

        // Quad output read with 8 dummy clocks
        exp_rd(8'h3C, 4'b1111); exp_rd(8'hC3, 4'b1111);
        select();
        send_cmd_addr(8'h6B, 24'h000010);
        idle_clocks(8 + 4);
        deselect("qread_release");

        // Page program without write enable is dropped
        select();
        send_cmd_addr(8'h02, 24'h000020);
        send_byte(8'hAA);
        deselect("pp_nowel_release");
        read_status(8'h00, "rdsr_nowel_release");

        // Write enable, then page program wrapping inside the page
        select();
        send_byte(8'h06);
        deselect("wren_release");
        read_status(8'h02, "rdsr_wel_release");
        exp_wr(16'h00FF, 8'h12);
        exp_wr(16'h0000, 8'h34);
        select();
        send_cmd_addr(8'h02, 24'h0000FF);
        send_byte(8'h12);
        send_byte(8'h34);
        deselect("pp_release");
        read_status(8'h00, "rdsr_after_pp_release");
        exp_rd(8'h12, 4'b0010);
        select();
        send_cmd_addr(8'h03, 24'h0000FF);
        idle_clocks(8);
        deselect("readback_release");

        // Deselect after 5 data bits: no write, WEL cleared
        select();
        send_byte(8'h06);
        deselect("wren2_release");
        select();
        send_cmd_addr(8'h02, 24'h000040);
        for (int i = 0; i < 5; i++) bit_xfer(1'b1);
        deselect("partial_pp_release");
        read_status(8'h00, "rdsr_after_abort_release");

        // Reset in the middle of a read while selected
        exp_rd(8'hA5, 4'b0010);
        select();
        send_cmd_addr(8'h03, 24'h00FFFE);
        idle_clocks(12);
        check("pre_rst_oe", 32'(oe), 32'h2);
        rst = 1'b1;
        wait_clks(1);
        check("rst_mid_oe", 32'(oe), 32'h0);
        rst = 1'b0;
        // Still selected after reset: this command must be ignored
        send_byte(8'h9F);
        idle_clocks(8);
        check("post_rst_still_quiet", 32'(oe), 32'h0);
        deselect("post_rst_release");
        exp_rd(8'hEF, 4'b0010); exp_rd(8'h40, 4'b0010); exp_rd(8'h16, 4'b0010);
        select();
        send_byte(8'h9F);
        idle_clocks(24);
        deselect("rdid2_release");

        wait_clks(20);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
